pipelined_addsub: RTL and testbench
===================================

# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake, registered status flags and optional signed saturation. An N-bit operation is split into STAGES equal carry-ripple segments, one segment per pipeline stage, so the carry chain per cycle is N/STAGES bits. The block is the successor to the team's combinational ripple adder/subtractor and is built from the existing FULL_ADDER cell. It sits in datapaths that need wide add/sub at high clock rates with backpressure.

## Interface
- N, 16, operand/result width; N ≥ 2.
- STAGES, 4, pipeline depth and segment count; 1 ≤ STAGES ≤ N; N % STAGES == 0 (elaboration error otherwise).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- x  in  N  operand A.
- y  in  N  operand B.
- control  in  1  0 = x+y, 1 = x−y (y inverted, carry-in 1).
- sat  in  1  1 = clamp signed overflow to the signed max/min value.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- s  out  N  result.
- cout  out  1  raw carry out of MSB (for subtract: 1 = no borrow).
- OVERFLOW  out  1  signed overflow of the unsaturated result.
- zero  out  1  s == 0 (after saturation).
- negative  out  1  s[N−1] (after saturation).

## Operation
- Segment width W = N/STAGES. Stage k (k = 1..STAGES) register holds: valid bit, result bits of segments 0..k−1, carry out of segment k−1, remaining upper bits of x and y (y already XORed with control), control, sat, x[N−1] and yeff[N−1].
- Acceptance edge: segment 0 is summed combinationally from the inputs with carry-in = control and captured into stage 1. Each subsequent edge sums the next segment using the registered carry.
- The final stage computes combinationally: raw sum, cout, OVERFLOW = (x[N−1] == yeff[N−1]) & (sum[N−1] != x[N−1]). It then registers the result to the outputs.
- Saturation: if sat & OVERFLOW, s = x[N−1] ? {1,0…0} : {0,1…1}; otherwise s = raw sum. OVERFLOW is reported regardless of sat. cout is never modified by saturation.
- Handshake: global enable en = ~out_valid | out_ready; in_ready = en. When en = 1, all stages advance together. When en = 0, all stages hold.
- Bubbles are not compressed. Stage valid bits propagate in lockstep.
- A beat transfers at the input when in_valid & in_ready. A beat transfers at the output when out_valid & out_ready.
- Results leave strictly in order; no beat is lost or duplicated.
- in_valid = 0 while en = 1 inserts a bubble (valid 0).
- STAGES = 1 degenerates to a registered single-cycle N-bit add/sub with flags.

## Timing
- Latency: with no stall, a beat accepted at edge t appears with out_valid = 1 after edge t+STAGES−1, i.e. STAGES edges after acceptance including the capture edge.
- Throughput: one beat per cycle when out_ready stays high.
- Reset (rst high at an edge) applies the following values:
  - all stage valid bits = 0 and out_valid = 0;
  - s = 0, cout = 0, OVERFLOW = 0, zero = 0, negative = 0;
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards every in-flight beat; none appears afterwards.
- Simultaneous output transfer and input acceptance is legal: a full pipeline with out_ready = 1 keeps streaming.
- Stall: while out_valid & ~out_ready, s and all flags hold stable and in_ready = 0.
- in_ready depends combinationally on out_ready; this is the only comb path from input to output.

## Structure
- Shared package addsub_pkg holds:
  - function seg_width(N, STAGES);
  - saturation constant generators smax(N) and smin(N);
  - the op encoding constants OP_ADD = 0 and OP_SUB = 1.
- One sub-module, addsub_segment: W-bit ripple of FULL_ADDER cells with cin/cout, instantiated STAGES times via generate.
- Stage registers and the handshake live in the top module.

## Test plan
All scenarios use N = 16, STAGES = 4 unless noted.
- 0x7FFF + 0x0001, control = 0, sat = 0 → s = 0x8000, OVERFLOW = 1, cout = 0, negative = 1, zero = 0. out_valid rises 4 edges after acceptance.
- Same operands, sat = 1 → s = 0x7FFF, OVERFLOW = 1, negative = 0.
- 0x0005 − 0x0005, control = 1 → s = 0x0000, zero = 1, cout = 1, OVERFLOW = 0.
- 0x8000 − 0x0001:
  - sat = 0 → s = 0x7FFF, OVERFLOW = 1, cout = 1;
  - sat = 1 → s = 0x8000, OVERFLOW = 1.
- 32 random back-to-back beats with out_ready toggling pseudo-randomly → in-order results matching the reference model, no loss or duplication, in_ready = 0 exactly when out_valid & ~out_ready. Repeat with STAGES = 1, 2, 16.
- rst asserted for one cycle with 3 beats in flight → out_valid = 0 and all outputs 0 on the next cycle; no pre-reset result ever appears. A new beat accepted right after reset emerges after 4 edges.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: segment sizing,
// signed saturation constants and the operation encoding.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Saturation constants are built 64 bits wide and truncated by the user.
    localparam int SAT_MAX_N = 64;

    function automatic int seg_width(input int n, input int stages);
        return n / stages;
    endfunction

    function automatic logic [63:0] smax(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] smin(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the ripple element of every segment.
module FULL_ADDER (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_addsub_segment.sv
// W-bit carry-ripple segment: one per pipeline stage.
module addsub_segment #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        FULL_ADDER u_fa (
            .i_a    (i_a[i]),
            .i_b    (i_b[i]),
            .i_cin  (w_c[i]),
            .o_sum  (o_sum[i]),
            .o_cout (w_c[i+1])
        );
    end

    assign o_cout = w_c[W];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub: one ripple segment per stage, global
// stall enable, registered result with status flags and optional saturation.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         control,
    input  logic         sat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         OVERFLOW,
    output logic         zero,
    output logic         negative
);

    localparam int W = seg_width(N, STAGES);
    localparam logic [63:0] SMAX64 = smax(N);
    localparam logic [63:0] SMIN64 = smin(N);
    localparam logic [N-1:0] SMAX = SMAX64[N-1:0];
    localparam logic [N-1:0] SMIN = SMIN64[N-1:0];

    if (N < 2 || N > SAT_MAX_N || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_addsub: illegal N/STAGES combination");
    end

    logic         r_out_valid;
    logic [N-1:0] r_s;
    logic         r_cout;
    logic         r_ovf;
    logic         r_zero;
    logic         r_neg;

    logic         w_en;
    logic [N-1:0] w_yeff;
    logic         w_cin0;
    logic         w_fin_valid;
    logic         w_fin_sat;
    logic         w_fin_xmsb;
    logic         w_fin_ymsb;
    logic         w_fin_cout;
    logic [N-1:0] w_fin_raw;
    logic         w_ovf;
    logic [N-1:0] w_sat_s;

    // valid/ready: a beat moves when valid & ready; every stage advances only while en is high.
    assign w_en     = ~r_out_valid | out_ready;
    assign in_ready = w_en;

    assign w_yeff = (control == OP_SUB) ? ~y : y;
    assign w_cin0 = (control == OP_SUB);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet summed when segment k is processed.
        localparam int REM = N - k * W;

        logic [REM-1:0]       w_src_x;
        logic [REM-1:0]       w_src_y;
        logic                 w_src_valid;
        logic                 w_src_sat;
        logic                 w_src_cin;
        logic [W-1:0]         w_seg_sum;
        logic                 w_seg_cout;
        logic [(k+1)*W-1:0]   w_next_part;

        if (k == 0) begin : g_src
            assign w_src_x     = x;
            assign w_src_y     = w_yeff;
            assign w_src_valid = in_valid;
            assign w_src_sat   = sat;
            assign w_src_cin   = w_cin0;
            assign w_next_part = w_seg_sum;
        end else begin : g_src
            assign w_src_x     = g_stage[k-1].g_reg.r_x;
            assign w_src_y     = g_stage[k-1].g_reg.r_y;
            assign w_src_valid = g_stage[k-1].g_reg.r_valid;
            assign w_src_sat   = g_stage[k-1].g_reg.r_sat;
            assign w_src_cin   = g_stage[k-1].g_reg.r_carry;
            assign w_next_part = {w_seg_sum, g_stage[k-1].g_reg.r_part};
        end

        addsub_segment #(.W(W)) u_seg (
            .i_a    (w_src_x[W-1:0]),
            .i_b    (w_src_y[W-1:0]),
            .i_cin  (w_src_cin),
            .o_sum  (w_seg_sum),
            .o_cout (w_seg_cout)
        );

        if (k < STAGES - 1) begin : g_reg
            logic                 r_valid;
            logic                 r_sat;
            logic                 r_carry;
            logic [(k+1)*W-1:0]   r_part;
            logic [REM-W-1:0]     r_x;
            logic [REM-W-1:0]     r_y;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_sat   <= 1'b0;
                    r_carry <= 1'b0;
                    r_part  <= '0;
                    r_x     <= '0;
                    r_y     <= '0;
                end else if (w_en) begin
                    r_valid <= w_src_valid;
                    r_sat   <= w_src_sat;
                    r_carry <= w_seg_cout;
                    r_part  <= w_next_part;
                    r_x     <= w_src_x[REM-1:W];
                    r_y     <= w_src_y[REM-1:W];
                end
            end
        end else begin : g_last
            assign w_fin_valid = w_src_valid;
            assign w_fin_sat   = w_src_sat;
            assign w_fin_xmsb  = w_src_x[W-1];
            assign w_fin_ymsb  = w_src_y[W-1];
            assign w_fin_cout  = w_seg_cout;
            assign w_fin_raw   = w_next_part;
        end
    end

    assign w_ovf   = (w_fin_xmsb == w_fin_ymsb) & (w_fin_raw[N-1] != w_fin_xmsb);
    assign w_sat_s = (w_fin_sat & w_ovf) ? (w_fin_xmsb ? SMIN : SMAX) : w_fin_raw;

    // The last segment, flags and saturation share the output register edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= w_fin_valid;
            r_s         <= w_sat_s;
            r_cout      <= w_fin_cout;
            r_ovf       <= w_ovf;
            r_zero      <= (w_sat_s == '0);
            r_neg       <= w_sat_s[N-1];
        end
    end

    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cout      = r_cout;
    assign OVERFLOW  = r_ovf;
    assign zero      = r_zero;
    assign negative  = r_neg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed corner cases on a 4-stage instance,
// then random streaming with backpressure on 4/1/2/16-stage instances.
module tb_pipelined_addsub;

  localparam int N = 16;
  localparam int NBEATS = 32;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic control;
  logic sat;

  logic ov[4];
  logic ir[4];
  logic co[4];
  logic of[4];
  logic ze[4];
  logic ne[4];
  logic [N-1:0] so[4];

  int checks = 0;
  int failures = 0;
  int sel = 0;
  bit mon_en = 1'b0;
  int acc_cnt = 0;
  int rcv_cnt = 0;
  bit prev_stall = 1'b0;
  logic [19:0] prev_pack;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_addsub #(.N(N), .STAGES(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .x(x), .y(y),
    .control(control), .sat(sat), .out_valid(ov[0]), .out_ready(out_ready),
    .s(so[0]), .cout(co[0]), .OVERFLOW(of[0]), .zero(ze[0]), .negative(ne[0])
  );
  pipelined_addsub #(.N(N), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .x(x), .y(y),
    .control(control), .sat(sat), .out_valid(ov[1]), .out_ready(out_ready),
    .s(so[1]), .cout(co[1]), .OVERFLOW(of[1]), .zero(ze[1]), .negative(ne[1])
  );
  pipelined_addsub #(.N(N), .STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .x(x), .y(y),
    .control(control), .sat(sat), .out_valid(ov[2]), .out_ready(out_ready),
    .s(so[2]), .cout(co[2]), .OVERFLOW(of[2]), .zero(ze[2]), .negative(ne[2])
  );
  pipelined_addsub #(.N(N), .STAGES(16)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .x(x), .y(y),
    .control(control), .sat(sat), .out_valid(ov[3]), .out_ready(out_ready),
    .s(so[3]), .cout(co[3]), .OVERFLOW(of[3]), .zero(ze[3]), .negative(ne[3])
  );

  // Reference: integer arithmetic on the signed/unsigned interpretations.
  function automatic logic [19:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic ctl, input logic sat_i);
    int sa, sb, ideal, ua, ub;
    logic ovf, c;
    logic [15:0] r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    ideal = ctl ? (sa - sb) : (sa + sb);
    ovf = (ideal > 32767) || (ideal < -32768);
    c = ctl ? (ua >= ub) : ((ua + ub) > 65535);
    if (ovf && sat_i) r = (ideal > 0) ? 16'h7FFF : 16'h8000;
    else r = ideal[15:0];
    return {r, c, ovf, (r == 16'h0000), r[15]};
  endfunction

  function automatic logic [19:0] pack_out(input int d);
    return {so[d], co[d], of[d], ze[d], ne[d]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard for the selected instance during random streaming.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready_rule", 32'(ir[sel]), 32'(!(ov[sel] && !out_ready)));
      if (prev_stall) chk("stall_hold", 32'(pack_out(sel)), 32'(prev_pack));
      if (in_valid && ir[sel]) begin
        exp_q.push_back(ref_model(x, y, control, sat));
        acc_cnt++;
      end
      if (ov[sel] && out_ready) begin
        rcv_cnt++;
        chk("rcv_le_acc", 32'(rcv_cnt <= acc_cnt), 32'd1);
        if (exp_q.size() > 0) chk("stream_result", 32'(pack_out(sel)), 32'(exp_q.pop_front()));
      end
      prev_stall = ov[sel] && !out_ready;
      prev_pack = pack_out(sel);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_beat(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic st, input logic [19:0] e);
    int edges;
    @(posedge clk); #1;
    x = a; y = b; control = c; sat = st; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    edges = 1;
    #1;
    in_valid = 1'b0;
    while (!ov[0] && edges < 20) begin
      @(posedge clk);
      edges++;
      #1;
    end
    chk({tag, "_latency"}, 32'(edges), 32'd4);
    chk({tag, "_valid"}, 32'(ov[0]), 32'd1);
    chk({tag, "_result"}, 32'(pack_out(0)), 32'(e));
  endtask

  task automatic run_random(input int d);
    sel = d;
    reset_dut();
    exp_q.delete();
    acc_cnt = 0;
    rcv_cnt = 0;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 3000 && !(acc_cnt == NBEATS && exp_q.size() == 0); cyc++) begin
      @(posedge clk); #1;
      in_valid = (acc_cnt < NBEATS) && ($urandom_range(0, 3) != 0);
      x = N'($urandom);
      y = N'($urandom);
      control = 1'($urandom_range(0, 1));
      sat = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    mon_en = 1'b0;
    chk($sformatf("beats_in_%0d", d), 32'(acc_cnt), 32'(NBEATS));
    chk($sformatf("beats_out_%0d", d), 32'(rcv_cnt), 32'(NBEATS));
    chk($sformatf("queue_empty_%0d", d), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    y = '0;
    control = 1'b0;
    sat = 1'b0;
    reset_dut();

    chk("reset_out_valid", 32'(ov[0]), 32'd0);
    chk("reset_outputs", 32'(pack_out(0)), 32'd0);
    chk("reset_in_ready", 32'(ir[0]), 32'd1);

    do_beat("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
    do_beat("add_sat", 16'h7FFF, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0});
    do_beat("sub_zero", 16'h0005, 16'h0005, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    do_beat("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, {16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0});
    do_beat("sub_sat", 16'h8000, 16'h0001, 1'b1, 1'b1, {16'h8000, 1'b1, 1'b1, 1'b0, 1'b1});

    // Three beats in flight, then a one-cycle reset.
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = 16'h1111 * 16'(i + 1);
      y = 16'h0101;
      control = 1'b0;
      sat = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(ov[0]), 32'd0);
    chk("midrst_outputs", 32'(pack_out(0)), 32'd0);
    chk("midrst_in_ready", 32'(ir[0]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("midrst_no_stale", 32'(ov[0]), 32'd0);
      @(posedge clk); #1;
    end
    do_beat("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, {16'h5555, 1'b0, 1'b0, 1'b0, 1'b0});

    for (int d = 0; d < 4; d++) run_random(d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
